// File: rtl/subtrator_serial_if.sv
// subtrator_serial_if -- operand/result bundle of the bit-serial subtractor.
//
// Signals:
//   start   request a subtraction (sampled only while the block is idle)
//   A, B    N-bit unsigned minuend / subtrahend
//   D       N-bit difference A-B modulo 2^N
//   borrow  high when A < B
//   busy    operation in progress
//   done    one-cycle pulse, D/borrow valid
//   ovf     signed overflow flag, present only when SUBTRATOR_OVF_EN is defined
//
// Modports: master drives the request side, slave is the subtractor.
interface subtrator_serial_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] D;
  logic         borrow;
  logic         busy;
  logic         done;
`ifdef SUBTRATOR_OVF_EN
  logic         ovf;

  modport master (output start, A, B, input D, borrow, busy, done, ovf);
  modport slave  (input start, A, B, output D, borrow, busy, done, ovf);
`else
  modport master (output start, A, B, input D, borrow, busy, done);
  modport slave  (input start, A, B, output D, borrow, busy, done);
`endif
endinterface

// File: rtl/subtrator_serial.sv
// subtrator_serial -- bit-serial unsigned subtractor, one bit per clock, LSB first.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    subtrator_serial_if.slave (start, A, B in; D, borrow, busy, done out)
//
// Operation: an accepted start loads A/B into shift registers, SHIFT then runs
// N cycles producing one difference bit per cycle, FIM presents the result for
// one cycle with done high, then the block returns to IDLE. D/borrow are only
// written on entry to FIM, so they keep the previous result during SHIFT.
//
// Optional feature: define SUBTRATOR_OVF_EN to add bus.ovf, the signed
// two's-complement overflow of A-B, updated and held together with D.
module subtrator_serial #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  subtrator_serial_if.slave   bus
);

  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIM   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   res_sh;
  logic [N-1:0]   d_q;
  logic           bin;
  logic           borrow_q;
  logic [CNT_W-1:0] cnt;

  logic           accept;
  logic           last_bit;
  logic           busy_c;
  logic           done_c;
  logic           d_bit;
  logic           bout;
  logic [N-1:0]   d_full;

`ifdef SUBTRATOR_OVF_EN
  logic           a_msb;
  logic           b_msb;
  logic           ovf_q;
`endif

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bi);
    logic d;
    logic bo;
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
    return {bo, d};
  endfunction

  assign {bout, d_bit} = sub_bit(a_sh[0], b_sh[0], bin);
  // Result as it will stand once the current bit has been shifted in at the MSB.
  assign d_full   = {d_bit, res_sh[N-1:1]};
  assign last_bit = (cnt == CNT_W'(N - 1));
  assign accept   = (state == IDLE) && bus.start;

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (last_bit) state_nxt = FIM;
      end
      FIM: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      bin      <= 1'b0;
      cnt      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.A;
      b_sh <= bus.B;
      bin  <= 1'b0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= d_full;
      bin    <= bout;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        d_q      <= d_full;
        borrow_q <= bout;
      end
    end
  end

`ifdef SUBTRATOR_OVF_EN
  // Operand sign bits are shifted out during SHIFT, so keep a copy for the
  // overflow decision made on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.A[N-1];
      b_msb <= bus.B[N-1];
    end else if ((state == SHIFT) && last_bit) begin
      ovf_q <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.D      = d_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = busy_c;
  assign bus.done   = done_c;

endmodule
